hdmi_burst_reader: RTL

//  Bus-master read engine between fill_fifo_fsm and the pixel FIFO that feeds hdmi_core.

---
 rtl/hdmi_burst_pkg.sv | 22 ++
 rtl/hdmi_burst_reader_if.sv | 29 ++
 rtl/hdmi_burst_reader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hdmi_burst_pkg.sv
// rtl/hdmi_burst_pkg.sv - shared types and helpers for the HDMI line burst reader
package hdmi_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        XFER
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Words in the next burst: the full burst size unless the line tail is shorter.
    function automatic logic [8:0] burst_words(input logic [10:0] remaining,
                                               input logic [8:0]  max_words);
        if ({2'b00, max_words} < remaining)
            return max_words;
        else
            return remaining[8:0];
    endfunction

endpackage

// File: rtl/hdmi_burst_reader_if.sv
// rtl/hdmi_burst_reader_if.sv - bus-master read request and data channel
interface hdmi_burst_reader_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int LW = 12
);
    logic          IP2Bus_MstRd_Req;
    logic [AW-1:0] IP2Bus_Mst_Addr;
    logic [LW-1:0] IP2Bus_Mst_Length;
    logic          Bus2IP_Mst_CmdAck;
    logic          Bus2IP_Mst_Cmplt;
    logic          Bus2IP_Mst_Error;
    logic [DW-1:0] Bus2IP_MstRd_d;
    logic          Bus2IP_MstRd_src_rdy_n;
    logic          IP2Bus_MstRd_dst_rdy_n;

    modport master (
        output IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_Length, IP2Bus_MstRd_dst_rdy_n,
        input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
               Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n
    );

    modport slave (
        input  IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_Length, IP2Bus_MstRd_dst_rdy_n,
        output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
               Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n
    );

endinterface

// File: rtl/hdmi_burst_reader.sv
// rtl/hdmi_burst_reader.sv - fetches one display line in bursts into the pixel FIFO
module hdmi_burst_reader
    import hdmi_burst_pkg::*;
#(
    parameter int C_MST_AWIDTH   = 32,
    parameter int C_MST_DWIDTH   = 32,
    parameter int C_LENGTH_WIDTH = 12,
    parameter int BURST_WORDS    = 16,
    parameter int FIFO_DEPTH     = 256
) (
    input  logic                    Bus2IP_Clk,
    input  logic                    Bus2IP_Reset,
    input  logic                    go_fill_fifo,
    input  logic [C_MST_AWIDTH-1:0] ddr_addr_to_read,
    input  logic [10:0]             line_words,
    input  logic [8:0]              fifo_level,
    output logic                    busy,
    output logic                    line_done,
    output logic                    err,
    output logic                    fifo_wr_en,
    output logic [C_MST_DWIDTH-1:0] fifo_wr_data,
    hdmi_burst_reader_if.master     mst
);

    localparam logic [9:0] DEPTH = 10'(FIFO_DEPTH);

    state_t                  state, state_n;
    logic [C_MST_AWIDTH-1:0] addr, addr_n;
    logic [10:0]             remaining, remaining_n;
    logic [8:0]              burst_len, burst_n;
    logic [9:0]              beat_cnt, beat_n;
    logic                    line_done_n;
    logic                    err_n;

    logic [8:0]  next_burst;
    logic [9:0]  space;
    logic [9:0]  beats_total;
    logic        in_xfer;

    assign in_xfer     = (state == XFER);
    assign next_burst  = burst_words(remaining, 9'(BURST_WORDS));
    // An over-range level reads as a full FIFO rather than wrapping the subtraction.
    assign space       = ({1'b0, fifo_level} >= DEPTH) ? 10'd0 : DEPTH - {1'b0, fifo_level};
    assign beats_total = beat_cnt + {9'd0, fifo_wr_en};

    assign fifo_wr_en   = in_xfer & ~mst.Bus2IP_MstRd_src_rdy_n;
    assign fifo_wr_data = in_xfer ? mst.Bus2IP_MstRd_d : '0;
    assign busy         = (state != IDLE);

    assign mst.IP2Bus_MstRd_Req       = (state == REQ);
    assign mst.IP2Bus_Mst_Addr        = addr;
    assign mst.IP2Bus_Mst_Length      = C_LENGTH_WIDTH'(burst_len) * C_LENGTH_WIDTH'(BYTES_PER_WORD);
    assign mst.IP2Bus_MstRd_dst_rdy_n = ~in_xfer;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            burst_len <= '0;
            beat_cnt  <= '0;
            line_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            remaining <= remaining_n;
            burst_len <= burst_n;
            beat_cnt  <= beat_n;
            line_done <= line_done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        remaining_n = remaining;
        burst_n     = burst_len;
        beat_n      = beat_cnt;
        line_done_n = 1'b0;
        err_n       = err;
        case (state)
            IDLE: begin
                if (go_fill_fifo) begin
                    addr_n      = ddr_addr_to_read;
                    remaining_n = line_words;
                    if (line_words == 11'd0)
                        line_done_n = 1'b1;
                    else
                        state_n = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                if ({3'b000, space} >= {4'b0000, next_burst}) begin
                    burst_n = next_burst;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (mst.Bus2IP_Mst_CmdAck) begin
                    beat_n  = '0;
                    state_n = XFER;
                end
            end
            XFER: begin
                beat_n = beats_total;
                // A beat arriving with Cmplt is already in beats_total for the length check.
                if (mst.Bus2IP_Mst_Cmplt) begin
                    if (mst.Bus2IP_Mst_Error || (beats_total != {1'b0, burst_len})) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        addr_n      = addr + C_MST_AWIDTH'(burst_len) * C_MST_AWIDTH'(BYTES_PER_WORD);
                        remaining_n = remaining - {2'b00, burst_len};
                        if (remaining == {2'b00, burst_len}) begin
                            line_done_n = 1'b1;
                            state_n     = IDLE;
                        end else begin
                            state_n = WAIT_SPACE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
